ysyx_220053_ifu: RTL and testbench
==================================

# ysyx_220053_ifu

Instruction fetch unit for the ysyx_220053 single-issue core. It holds the PC, issues one 32-bit read per instruction to instruction memory over a valid/ready request and valid response interface, and presents the fetched word and its PC to the decode/control stage with a valid/ready handshake. It is the producer side of the decoder's `instr_i`. Branch and jump targets resolved downstream come back on a redirect port, which flushes any in-flight fetch.

## Interface
- RESET_PC, 32'h8000_0000, PC loaded at reset
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  fetch address, word aligned
- imem_resp_valid  in  1  read data valid
- imem_resp_data  in  32  read data
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode consumes instruction
- inst_o  out  32  instruction word
- inst_pc  out  32  PC of inst_o
- redirect_valid  in  1  downstream requests PC change
- redirect_pc  in  32  new PC; bits [1:0] ignored, forced 0
- halted  out  1  fetch stopped on ebreak (see Configuration)

## Operation
- States: IDLE, FETCH, WAIT, HOLD, HALT. All outputs are registered.
- Reset values:
  - state=IDLE, pc=RESET_PC, kill=0
  - imem_req_valid=0, imem_req_addr=RESET_PC
  - inst_valid=0, inst_o=0, inst_pc=0, halted=0
- IDLE: always goes to FETCH next cycle. Drives imem_req_valid=1 and imem_req_addr=pc.
- FETCH: holds imem_req_valid and imem_req_addr stable until imem_req_valid && imem_req_ready, then goes to WAIT with req_valid=0.
- WAIT: on imem_resp_valid:
  - if kill=0: capture inst_o=resp_data and inst_pc=pc, set inst_valid=1, go to HOLD.
  - if kill=1: discard the data, clear kill, go to IDLE.
- HOLD: inst_valid, inst_o and inst_pc stay stable until inst_ready. On the handshake: inst_valid=0, pc=pc+4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0), go to IDLE.
- imem_resp_valid outside WAIT is ignored.
- Redirect (priority over normal flow), pc=redirect_pc&~3:
  - IDLE: next request uses the new pc.
  - FETCH, request not accepted: drop req_valid, go to IDLE.
  - FETCH, request accepted in the same cycle: set kill, go to WAIT.
  - WAIT: set kill. If resp_valid arrives in the same cycle, discard it and go to IDLE.
  - HOLD: drop inst_valid, go to IDLE. If inst_ready is high in the same cycle, the handshake counts as consumed, but pc takes the redirect target, not +4.
  - HALT: redirect is ignored.
- Only one request is ever outstanding.

## Timing
- Request accepted in cycle t, response in t+k (k≥1): inst_valid rises at t+k+1.
- Decode handshake in cycle t: next imem_req_valid at t+2 (IDLE, then FETCH).
- Redirect sampled in cycle t: request for the new pc is asserted no earlier than t+2. It is delayed until any killed response returns.
- Reset assertion mid-transaction clears state immediately. Responses arriving after reset are ignored because state is not WAIT.

## Configuration
- YSYX_220053_IFU_EBREAK_HALT_EN defined:
  - When the decode handshake completes with inst_o==32'h0010_0073 (ebreak), go to HALT.
  - In HALT: halted=1, no further requests, redirect ignored. Only rst_n exits HALT.
- Undefined: halted is tied to 0, ebreak is fetched like any other instruction, and the HALT state does not exist.

## Test plan
- Reset release with imem ready and 1-cycle response, inst_ready=1: requests at 8000_0000, 8000_0004, 8000_0008; inst_pc matches each address and inst_o equals the memory words.
- inst_ready held low 5 cycles: inst_valid, inst_o and inst_pc stay stable and no new request issues; after ready goes high, the next request is at pc+4 two cycles later.
- Redirect to 8000_0102 while in WAIT with a 3-cycle response: the stale response is dropped (inst_valid stays 0) and the next request address is 8000_0100.
- Redirect to 8000_0040 in the same cycle as the decode handshake at 8000_0010: the next request is 8000_0040, not 8000_0014.
- pc=FFFF_FFFC handshake: next request at 0000_0000. Reset asserted during WAIT: the late response is ignored and fetch restarts at RESET_PC.
- With YSYX_220053_IFU_EBREAK_HALT_EN defined, memory returns 0010_0073: after the handshake halted=1 and imem_req_valid stays 0 for 20 cycles despite a redirect.

Source files
------------

// File: rtl/ysyx_220053_ifu.sv
// ysyx_220053_ifu: PC register and single-outstanding fetch FSM feeding decode.
// Optional halt-on-ebreak is enabled by defining YSYX_220053_IFU_EBREAK_HALT_EN.
module ysyx_220053_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
`ifdef YSYX_220053_IFU_EBREAK_HALT_EN
    localparam logic [2:0]  S_HALT = 3'd4;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
`endif

    logic [2:0]  r_state;
    logic [31:0] r_pc;
    logic        r_kill;
    logic        r_req_valid;
    logic [31:0] r_req_addr;
    logic        r_inst_valid;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;

    logic [31:0] w_redirect_pc;
    logic        w_req_fire;

    assign w_redirect_pc = redirect_pc & ~32'd3;
    assign w_req_fire    = r_req_valid & imem_req_ready;

    // NOTE: all state uses non-blocking assignments so every branch reads pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_kill       <= 1'b0;
            r_req_valid  <= 1'b0;
            r_req_addr   <= RESET_PC;
            r_inst_valid <= 1'b0;
            r_inst       <= 32'd0;
            r_inst_pc    <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A redirect here only retargets pc; the request waits one more cycle.
                    if (redirect_valid) begin
                        r_pc <= w_redirect_pc;
                    end else begin
                        r_req_valid <= 1'b1;
                        r_req_addr  <= r_pc;
                        r_state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (redirect_valid) begin
                        r_pc        <= w_redirect_pc;
                        r_req_valid <= 1'b0;
                        if (w_req_fire) begin
                            r_kill  <= 1'b1;
                            r_state <= S_WAIT;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (w_req_fire) begin
                        r_req_valid <= 1'b0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        r_pc <= w_redirect_pc;
                        if (imem_resp_valid) begin
                            r_kill  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_kill  <= 1'b1;
                        end
                    end else if (imem_resp_valid) begin
                        if (r_kill) begin
                            r_kill  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_inst       <= imem_resp_data;
                            r_inst_pc    <= r_pc;
                            r_inst_valid <= 1'b1;
                            r_state      <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (redirect_valid) begin
                        r_inst_valid <= 1'b0;
                        r_pc         <= w_redirect_pc;
                        r_state      <= S_IDLE;
                    end else if (inst_ready) begin
                        r_inst_valid <= 1'b0;
                        r_pc         <= r_pc + 32'd4;
`ifdef YSYX_220053_IFU_EBREAK_HALT_EN
                        r_state      <= (r_inst == EBREAK) ? S_HALT : S_IDLE;
`else
                        r_state      <= S_IDLE;
`endif
                    end
                end
`ifdef YSYX_220053_IFU_EBREAK_HALT_EN
                S_HALT: begin
                    r_state <= S_HALT;
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef YSYX_220053_IFU_EBREAK_HALT_EN
    logic r_halted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_halted <= 1'b0;
        end else if (r_state == S_HOLD && !redirect_valid && inst_ready && r_inst == EBREAK) begin
            r_halted <= 1'b1;
        end
    end

    assign halted = r_halted;
`else
    assign halted = 1'b0;
`endif

    assign imem_req_valid = r_req_valid;
    assign imem_req_addr  = r_req_addr;
    assign inst_valid     = r_inst_valid;
    assign inst_o         = r_inst;
    assign inst_pc        = r_inst_pc;

endmodule

// File: tb/tb_ysyx_220053_ifu.sv
// Self-checking bench for ysyx_220053_ifu: reset vector table, directed corner
// sequences, then randomized traffic against a PC-sequence reference model.
module tb_ysyx_220053_ifu;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] EBREAK   = 32'h0010_0073;
    localparam logic [31:0] W0 = 32'h0000_0413;
    localparam logic [31:0] W1 = 32'h0040_0493;
    localparam logic [31:0] W2 = 32'h0084_0513;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'd0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_o;
    logic [31:0] inst_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        halted;

    ysyx_220053_ifu #(.RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_o          (inst_o),
        .inst_pc         (inst_pc),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .halted          (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rdata;
        logic        irdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs [12];

    int n_tests = 0;
    int n_fail  = 0;

    // Memory model: one pending read, answered mem_lat cycles after acceptance.
    bit          pend = 1'b0;
    int          cd = 0;
    logic [31:0] paddr = 32'd0;
    int          mem_lat = 1;
    int          mem_ready_pct = 100;
    logic [31:0] ebreak_addr = 32'h1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        if (a == ebreak_addr) return EBREAK;
        w = {a[15:0], ~a[31:16]} ^ 32'h1357_9BDE;
        w[0] = 1'b0;
        return w;
    endfunction

    function automatic logic [31:0] b(input logic x);
        return {31'd0, x};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic mem_drive();
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom;
        if (pend) begin
            if (cd == 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_word(paddr);
                pend = 1'b0;
            end else begin
                cd--;
            end
        end
        imem_req_ready = (int'($urandom_range(99)) < mem_ready_pct);
        if (imem_req_valid && imem_req_ready) begin
            check("one_outstanding", b(pend), 32'd0);
            pend  = 1'b1;
            cd    = mem_lat - 1;
            paddr = imem_req_addr;
        end
    endtask

    task automatic cycle();
        mem_drive();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_req(input string name, input logic [31:0] exp_addr, output int n);
        n = 0;
        while (!imem_req_valid && n < 50) begin
            cycle();
            n++;
        end
        check({name, "_req_seen"}, b(imem_req_valid), 32'd1);
        check({name, "_req_addr"}, imem_req_addr, exp_addr);
    endtask

    task automatic wait_inst(input string name, input logic [31:0] exp_pc);
        int n = 0;
        while (!inst_valid && n < 50) begin
            cycle();
            n++;
        end
        check({name, "_inst_seen"}, b(inst_valid), 32'd1);
        check({name, "_inst_pc"}, inst_pc, exp_pc);
        check({name, "_inst_o"}, inst_o, mem_word(exp_pc));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        pend = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_req_valid"}, b(imem_req_valid), 32'd0);
        check({name, "_req_addr"}, imem_req_addr, RESET_PC);
        check({name, "_inst_valid"}, b(inst_valid), 32'd0);
        check({name, "_inst_o"}, inst_o, 32'd0);
        check({name, "_inst_pc"}, inst_pc, 32'd0);
        check({name, "_halted"}, b(halted), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        bit          bad;
        logic [31:0] hold_pc, hold_o, exp_pc, prev_pc, prev_o;
        bit          prev_stall;
        int          n_hs;

        vecs[0]  = '{1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0,         1'b0, 32'd0, 32'd0};
        vecs[1]  = '{1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 32'd0, 32'd0};
        vecs[2]  = '{1'b1, 1'b1, W0,    1'b1, 1'b0, 32'd0,         1'b0, 32'd0, 32'd0};
        vecs[3]  = '{1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0,         1'b1, W0,    32'h8000_0000};
        vecs[4]  = '{1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0,         1'b0, 32'd0, 32'd0};
        vecs[5]  = '{1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'h8000_0004, 1'b0, 32'd0, 32'd0};
        vecs[6]  = '{1'b1, 1'b1, W1,    1'b1, 1'b0, 32'd0,         1'b0, 32'd0, 32'd0};
        vecs[7]  = '{1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0,         1'b1, W1,    32'h8000_0004};
        vecs[8]  = '{1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0,         1'b0, 32'd0, 32'd0};
        vecs[9]  = '{1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'h8000_0008, 1'b0, 32'd0, 32'd0};
        vecs[10] = '{1'b1, 1'b1, W2,    1'b1, 1'b0, 32'd0,         1'b0, 32'd0, 32'd0};
        vecs[11] = '{1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0,         1'b1, W2,    32'h8000_0008};

        do_reset();
        check_reset_values("reset");

        // Back-to-back fetches with a 1-cycle memory and decode always ready.
        for (int i = 0; i < 12; i++) begin
            check($sformatf("vec%0d_req_valid", i), b(imem_req_valid), b(vecs[i].e_req));
            if (vecs[i].e_req) check($sformatf("vec%0d_req_addr", i), imem_req_addr, vecs[i].e_addr);
            check($sformatf("vec%0d_inst_valid", i), b(inst_valid), b(vecs[i].e_iv));
            if (vecs[i].e_iv) begin
                check($sformatf("vec%0d_inst_o", i), inst_o, vecs[i].e_inst);
                check($sformatf("vec%0d_inst_pc", i), inst_pc, vecs[i].e_pc);
            end
            imem_req_ready  = vecs[i].rdy;
            imem_resp_valid = vecs[i].rv;
            imem_resp_data  = vecs[i].rdata;
            inst_ready      = vecs[i].irdy;
            @(posedge clk);
            @(negedge clk);
        end
        imem_resp_valid = 1'b0;
        inst_ready = 1'b0;
        mem_lat = 1;
        mem_ready_pct = 100;

        // Decode stalls for 5 cycles: outputs frozen, no new request.
        wait_inst("stall", 32'h8000_000C);
        hold_pc = inst_pc;
        hold_o  = inst_o;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check($sformatf("stall%0d_iv", i), b(inst_valid), 32'd1);
            check($sformatf("stall%0d_pc", i), inst_pc, hold_pc);
            check($sformatf("stall%0d_o", i), inst_o, hold_o);
            check($sformatf("stall%0d_no_req", i), b(imem_req_valid), 32'd0);
        end
        inst_ready = 1'b1;
        cycle();
        inst_ready = 1'b0;
        check("stall_t1_no_req", b(imem_req_valid), 32'd0);
        cycle();
        check("stall_t2_req", b(imem_req_valid), 32'd1);
        check("stall_t2_addr", imem_req_addr, 32'h8000_0010);

        // Redirect coincident with the decode handshake wins over pc+4.
        wait_inst("redir_hs", 32'h8000_0010);
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0040;
        mem_lat = 3;
        cycle();
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        check("redir_hs_iv_drop", b(inst_valid), 32'd0);
        wait_req("redir_hs", 32'h8000_0040, n);

        // Redirect while waiting on a 3-cycle response: stale data dropped.
        cycle();
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0102;
        cycle();
        redirect_valid = 1'b0;
        mem_lat = 1;
        bad = 1'b0;
        n = 0;
        while (!imem_req_valid && n < 50) begin
            if (inst_valid) bad = 1'b1;
            cycle();
            n++;
        end
        check("redir_wait_no_inst", b(bad), 32'd0);
        check("redir_wait_delay", b(n >= 1), 32'd1);
        check("redir_wait_req_seen", b(imem_req_valid), 32'd1);
        check("redir_wait_req_addr", imem_req_addr, 32'h8000_0100);

        // Redirect in HOLD to top of memory, then pc wraps to zero.
        wait_inst("wrap_pre", 32'h8000_0100);
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        cycle();
        redirect_valid = 1'b0;
        check("wrap_hold_drop", b(inst_valid), 32'd0);
        wait_req("wrap_top", 32'hFFFF_FFFC, n);
        wait_inst("wrap_top", 32'hFFFF_FFFC);
        inst_ready = 1'b1;
        mem_lat = 3;
        cycle();
        inst_ready = 1'b0;
        wait_req("wrap_zero", 32'h0000_0000, n);

        // Reset during WAIT: the late response must not be captured.
        cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        check_reset_values("midreset");
        mem_lat = 1;
        wait_inst("post_reset", RESET_PC);

        // ebreak handling.
        inst_ready = 1'b1;
        cycle();
        inst_ready = 1'b0;
        ebreak_addr = 32'h8000_0004;
        wait_inst("ebreak", 32'h8000_0004);
        check("ebreak_word", inst_o, EBREAK);
        inst_ready = 1'b1;
        cycle();
        inst_ready = 1'b0;
`ifdef YSYX_220053_IFU_EBREAK_HALT_EN
        check("halt_set", b(halted), 32'd1);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            redirect_valid = (i == 2);
            redirect_pc = 32'h8000_0200;
            cycle();
            if (imem_req_valid || !halted) bad = 1'b1;
        end
        redirect_valid = 1'b0;
        check("halt_stays", b(bad), 32'd0);
`else
        check("no_halt", b(halted), 32'd0);
        wait_req("after_ebreak", 32'h8000_0008, n);
`endif
        ebreak_addr = 32'h1;

        // Randomized traffic against the PC-sequence model.
        do_reset();
        exp_pc = RESET_PC;
        prev_stall = 1'b0;
        prev_pc = 32'd0;
        prev_o = 32'd0;
        n_hs = 0;
        mem_ready_pct = 70;
        for (int c = 0; c < 3000; c++) begin
            inst_ready     = (int'($urandom_range(99)) < 70);
            redirect_valid = (int'($urandom_range(99)) < 5);
            redirect_pc    = $urandom;
            if (prev_stall) begin
                check("rnd_stall_iv", b(inst_valid), 32'd1);
                check("rnd_stall_pc", inst_pc, prev_pc);
                check("rnd_stall_o", inst_o, prev_o);
            end
            if (inst_valid && inst_ready) begin
                check("rnd_inst_pc", inst_pc, exp_pc);
                check("rnd_inst_o", inst_o, mem_word(exp_pc));
                n_hs++;
            end
            if (imem_req_valid) check("rnd_req_align", b(imem_req_addr[1:0] != 2'b00), 32'd0);
            prev_stall = inst_valid && !inst_ready && !redirect_valid;
            prev_pc = inst_pc;
            prev_o  = inst_o;
            if (redirect_valid) exp_pc = redirect_pc & ~32'd3;
            else if (inst_valid && inst_ready) exp_pc = exp_pc + 32'd4;
            mem_lat = $urandom_range(4, 1);
            cycle();
        end
        redirect_valid = 1'b0;
        inst_ready = 1'b0;
        check("rnd_progress", b(n_hs >= 50), 32'd1);
        check("rnd_not_halted", b(halted), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
